// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM defaults and sequencer state encoding
package pwm_pkg;

    // Defaults shared with the free-running PWM core
    localparam int PWM_R     = 6;
    localparam int PWM_DEPTH = 36;
    localparam int PWM_AW    = 6;
    localparam int PWM_N     = 2000;
    localparam int PWM_NW    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pwm_seq_ctrl_if.sv
// rtl/pwm_seq_ctrl_if.sv - control, table-write and duty signals of the PWM sequencer
interface pwm_seq_ctrl_if
    import pwm_pkg::*;
#(
    parameter int R  = PWM_R,
    parameter int AW = PWM_AW
) ();

    logic          start;
    logic          stop;
    logic          loop_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [R-1:0]  wr_data;
    logic          pwm_wrap;
    logic [R-1:0]  duty;
    logic [AW-1:0] step_idx;
    logic          busy;
    logic          done;

    modport master (
        output start, stop, loop_en, wr_en, wr_addr, wr_data, pwm_wrap,
        input  duty, step_idx, busy, done
    );

    modport slave (
        input  start, stop, loop_en, wr_en, wr_addr, wr_data, pwm_wrap,
        output duty, step_idx, busy, done
    );

endinterface

// File: rtl/pwm_duty_table.sv
// rtl/pwm_duty_table.sv - DEPTH x R duty register file, sync write, combinational read
module pwm_duty_table
    import pwm_pkg::*;
#(
    parameter int R     = PWM_R,
    parameter int DEPTH = PWM_DEPTH,
    parameter int AW    = PWM_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [R-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [R-1:0]  rd_data
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [R-1:0] mem [DEPTH];
    logic         wr_ok;

    // Addresses past the last entry are dropped rather than aliased
    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_W);

    // Table storage; the read below sees the pre-write value on a write cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pwm_seq_ctrl.sv
// rtl/pwm_seq_ctrl.sv - duty-table sequencer that updates PWM duty on period boundaries
module pwm_seq_ctrl
    import pwm_pkg::*;
#(
    parameter int R     = PWM_R,
    parameter int DEPTH = PWM_DEPTH,
    parameter int AW    = PWM_AW,
    parameter int N     = PWM_N,
    parameter int NW    = PWM_NW
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_seq_ctrl_if.slave bus
);

    localparam logic [NW-1:0] N_LAST   = NW'(N - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

    seq_state_t    state, state_nxt;
    logic [NW-1:0] n, n_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic [AW-1:0] rd_addr;
    logic [R-1:0]  duty, duty_nxt;
    logic [R-1:0]  rd_data;
    logic          stop_pend, stop_pend_nxt;
    logic          done, done_nxt;
    logic          busy;

    pwm_duty_table #(
        .R     (R),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Entry that the next step would load: successor in RUN (wrapping), entry 0 otherwise
    always_comb begin
        rd_addr = '0;
        if (state == RUN && idx != IDX_LAST) begin
            rd_addr = idx + AW'(1);
        end
    end

    // Next-state logic; everything that touches duty happens only on pwm_wrap
    always_comb begin
        state_nxt     = state;
        n_nxt         = n;
        idx_nxt       = idx;
        duty_nxt      = duty;
        stop_pend_nxt = stop_pend;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                duty_nxt      = '0;
                stop_pend_nxt = 1'b0;
                if (bus.start) begin
                    state_nxt = ARM;
                    idx_nxt   = '0;
                    n_nxt     = '0;
                end
            end
            ARM, RUN: begin
                if (bus.pwm_wrap) begin
                    if (stop_pend || bus.stop) begin
                        state_nxt     = IDLE;
                        duty_nxt      = '0;
                        idx_nxt       = '0;
                        n_nxt         = '0;
                        stop_pend_nxt = 1'b0;
                    end else if (state == ARM) begin
                        state_nxt = RUN;
                        duty_nxt  = rd_data;
                        n_nxt     = '0;
                    end else if (n != N_LAST) begin
                        n_nxt = n + NW'(1);
                    end else if (idx != IDX_LAST || bus.loop_en) begin
                        n_nxt    = '0;
                        idx_nxt  = rd_addr;
                        duty_nxt = rd_data;
                    end else begin
                        state_nxt = IDLE;
                        duty_nxt  = '0;
                        idx_nxt   = '0;
                        n_nxt     = '0;
                        done_nxt  = 1'b1;
                    end
                end else if (bus.stop) begin
                    stop_pend_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                duty_nxt  = '0;
                idx_nxt   = '0;
                n_nxt     = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n         <= '0;
            idx       <= '0;
            duty      <= '0;
            stop_pend <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            n         <= n_nxt;
            idx       <= idx_nxt;
            duty      <= duty_nxt;
            stop_pend <= stop_pend_nxt;
            done      <= done_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

    assign bus.duty     = duty;
    assign bus.step_idx = idx;
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb/tb_pwm_seq_ctrl.sv - directed table-driven bench for pwm_seq_ctrl with a PWM counter model
module tb_pwm_seq_ctrl;

    localparam int R     = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int N     = 3;
    localparam int NW    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pwm_seq_ctrl_if #(.R(R), .AW(AW)) bus ();

    pwm_seq_ctrl #(
        .R     (R),
        .DEPTH (DEPTH),
        .AW    (AW),
        .N     (N),
        .NW    (NW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running PWM core: counter q, wrap pulse on the last count
    logic [R-1:0] q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= q + 1'b1;
    end
    assign bus.pwm_wrap = (q == '1);

    int period_cnt  = 0;
    int done_cycles = 0;

    always @(posedge clk) begin
        if (bus.pwm_wrap) period_cnt <= period_cnt + 1;
        if (bus.done)     done_cycles <= done_cycles + 1;
    end

    int tests = 0;
    int fails = 0;
    int p0    = 0;

    typedef struct {
        int           scen;
        bit           loop_en;
        bit           with_stop;
        bit           start_mid;
        int           k;
        logic [R-1:0] duty;
        logic [AW-1:0] idx;
        logic         busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_at(input int per, input int qv);
        bit hit = 1'b0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(negedge clk);
            if (period_cnt == per && int'(q) == qv) hit = 1'b1;
        end
        if (!hit) begin
            tests++;
            fails++;
            $display("FAIL timeout: period %0d q %0d not reached", per, qv);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = R'(d);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Start a sequence at q==4 of the next period; p0 is the period it was started in
    task automatic start_seq(input bit lp, input bit with_stop);
        wait_at(period_cnt + 1, 4);
        p0 = period_cnt;
        bus.loop_en = lp;
        bus.stop    = with_stop;
        pulse_start();
        bus.stop    = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int d, input int i, input int b);
        check({tag, " duty"}, 32'(bus.duty), 32'(d));
        check({tag, " idx"},  32'(bus.step_idx), 32'(i));
        check({tag, " busy"}, 32'(bus.busy), 32'(b));
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // period k: k-th full PWM period after the ARM wrap (k=-1 is the start period)
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0, -1, 4'd0,  3'd0, 1'b1});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0,  0, 4'd3,  3'd0, 1'b1});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0,  2, 4'd3,  3'd0, 1'b1});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0,  3, 4'd7,  3'd1, 1'b1});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b1,  4, 4'd7,  3'd1, 1'b1});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0,  5, 4'd7,  3'd1, 1'b1});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0,  6, 4'd11, 3'd2, 1'b1});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0,  8, 4'd11, 3'd2, 1'b1});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0,  9, 4'd15, 3'd3, 1'b1});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0, 11, 4'd15, 3'd3, 1'b1});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0, 12, 4'd0,  3'd0, 1'b0});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0, 13, 4'd0,  3'd0, 1'b0});
        vecs.push_back('{1, 1'b1, 1'b1, 1'b0,  0, 4'd3,  3'd0, 1'b1});
        vecs.push_back('{1, 1'b1, 1'b1, 1'b0,  3, 4'd7,  3'd1, 1'b1});
        vecs.push_back('{1, 1'b1, 1'b1, 1'b0,  6, 4'd11, 3'd2, 1'b1});
        vecs.push_back('{1, 1'b1, 1'b1, 1'b1,  9, 4'd15, 3'd3, 1'b1});
        vecs.push_back('{1, 1'b1, 1'b1, 1'b0, 11, 4'd15, 3'd3, 1'b1});
        vecs.push_back('{1, 1'b1, 1'b1, 1'b0, 12, 4'd3,  3'd0, 1'b1});
        vecs.push_back('{1, 1'b1, 1'b1, 1'b0, 13, 4'd3,  3'd0, 1'b1});

        // Reset state
        repeat (3) @(negedge clk);
        check_outs("reset", 0, 0, 0);
        check("reset done", 32'(bus.done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        wr(0, 3); wr(1, 7); wr(2, 11); wr(3, 15);
        pulse_stop();
        check_outs("idle stop", 0, 0, 0);

        // One-shot then looping playback, incl. start while busy and start+stop in IDLE
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].scen != vecs[i-1].scen) begin
                if (i > 0) check("done after one-shot", 32'(done_cycles), 1);
                start_seq(vecs[i].loop_en, vecs[i].with_stop);
            end
            if (vecs[i].start_mid) begin
                wait_at(p0 + 1 + vecs[i].k, 2);
                pulse_start();
            end
            wait_at(p0 + 1 + vecs[i].k, 8);
            check_outs($sformatf("v%0d", i), int'(vecs[i].duty), int'(vecs[i].idx), int'(vecs[i].busy));
        end
        check("done in loop", 32'(done_cycles), 1);
        pulse_stop();
        wait_at(period_cnt + 1, 1);
        check_outs("loop stopped", 0, 0, 0);

        // Stop 5 clk after entry 1 loads: takes effect at the next wrap
        start_seq(1'b0, 1'b0);
        wait_at(p0 + 4, 4);
        pulse_stop();
        wait_at(p0 + 4, 15);
        check_outs("stop pending", 7, 1, 1);
        wait_at(p0 + 5, 0);
        check_outs("stop applied", 0, 0, 0);
        check("stop no done", 32'(done_cycles), 1);

        // Stop coincident with a wrap
        start_seq(1'b0, 1'b0);
        wait_at(p0 + 2, 15);
        check_outs("pre wrap stop", 3, 0, 1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check_outs("wrap stop", 0, 0, 0);

        // Asynchronous reset mid-RUN clears outputs and the table
        start_seq(1'b1, 1'b0);
        wait_at(p0 + 8, 8);
        check_outs("pre reset", 11, 2, 1);
        rst_n = 1'b0;
        #1;
        check_outs("async reset", 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_seq(1'b1, 1'b0);
        wait_at(p0 + 1, 8);
        check_outs("zero table e0", 0, 0, 1);
        wait_at(p0 + 4, 8);
        check_outs("zero table e1", 0, 1, 1);
        pulse_stop();
        wait_at(period_cnt + 1, 1);
        check_outs("zero stopped", 0, 0, 0);

        // Write on the wrap that loads entry 2 (read-before-write), out-of-range write
        wr(0, 3); wr(1, 7); wr(2, 11); wr(3, 15);
        start_seq(1'b1, 1'b0);
        wait_at(p0 + 6, 15);
        check_outs("before load e2", 7, 1, 1);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd2;
        bus.wr_data = 4'd9;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        check_outs("load e2 old", 11, 2, 1);
        wr(5, 1);
        wait_at(p0 + 13, 8);
        check_outs("loop2 e0", 3, 0, 1);
        wait_at(p0 + 16, 8);
        check_outs("loop2 e1", 7, 1, 1);
        wait_at(p0 + 19, 8);
        check_outs("loop2 e2 new", 9, 2, 1);
        wait_at(p0 + 22, 8);
        check_outs("loop2 e3", 15, 3, 1);
        pulse_stop();
        wait_at(period_cnt + 1, 1);
        check_outs("final stop", 0, 0, 0);
        check("final done", 32'(done_cycles), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
